// File: rtl/io_uart_if.sv
// rtl/io_uart_if.sv - IO port bundle (index, write data, write strobe, read data) for io_uart.
interface io_uart_if;
  logic [3:0]  IOA;
  logic [31:0] IOD;
  logic        IOE;
  logic [31:0] IOQ;

  modport master (output IOA, output IOD, output IOE, input IOQ);
  modport slave  (input IOA, input IOD, input IOE, output IOQ);
endinterface

// File: rtl/io_uart.sv
// rtl/io_uart.sv - 8N1 UART on the IO port: TX FIFO + serialiser, mid-bit RX sampler, programmable bit period.
// Optional register 3 CTRL (internal TXD->RX loopback) enabled by IO_UART_LOOPBACK_EN.
module io_uart #(
  parameter int          TX_DEPTH_LOG2 = 2,
  parameter int unsigned DIV_RESET     = 433
) (
  input  logic     CLK,
  input  logic     N_RST,
  io_uart_if.slave bus,
  output logic     TXD,
  input  logic     RXD
);
  localparam int DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int PW    = TX_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  logic        wr_data, wr_status, wr_div;
  logic        clr_pop, clr_tx_ovf, clr_rx_ovf;
  logic [15:0] divisor;
  logic        tx_ovf, rx_ovf, rx_valid;
  logic [7:0]  rx_byte;
  logic        tx_idle;

  assign wr_data    = bus.IOE && (bus.IOA == 4'd0);
  assign wr_status  = bus.IOE && (bus.IOA == 4'd1);
  assign wr_div     = bus.IOE && (bus.IOA == 4'd2);
  assign clr_pop    = wr_status && bus.IOD[0];
  assign clr_tx_ovf = wr_status && bus.IOD[1];
  assign clr_rx_ovf = wr_status && bus.IOD[2];

  // TX FIFO: extra pointer MSB separates full from empty
  logic [7:0]    fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, fifo_push, tx_pop;
  logic [7:0]    fifo_head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                      (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign fifo_push  = wr_data && !fifo_full;
  assign fifo_head  = fifo_mem[rd_ptr[PW-2:0]];

  always_ff @(posedge CLK) begin
    if (fifo_push) fifo_mem[wr_ptr[PW-2:0]] <= bus.IOD[7:0];
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PW'(1);
      if (tx_pop)    rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // TX serialiser
  tx_state_t   tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        txd_n;

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      TXD      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      TXD      <= txd_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    txd_n      = TXD;
    tx_pop     = 1'b0;
    if (tx_state != TX_IDLE && tx_cnt != 16'd0) begin
      tx_cnt_n = tx_cnt - 16'd1;
    end else begin
      case (tx_state)
        TX_IDLE, TX_STOP: begin
          // Popping straight out of STOP chains frames with no idle gap
          if (!fifo_empty) begin
            tx_pop     = 1'b1;
            tx_shift_n = fifo_head;
            tx_cnt_n   = divisor;
            tx_state_n = TX_START;
            txd_n      = 1'b0;
          end else begin
            tx_state_n = TX_IDLE;
            txd_n      = 1'b1;
          end
        end
        TX_START: begin
          tx_state_n = TX_DATA;
          tx_bit_n   = 3'd0;
          tx_cnt_n   = divisor;
          txd_n      = tx_shift[0];
          tx_shift_n = {1'b0, tx_shift[7:1]};
        end
        TX_DATA: begin
          tx_cnt_n = divisor;
          if (tx_bit == 3'd7) begin
            tx_state_n = TX_STOP;
            txd_n      = 1'b1;
          end else begin
            tx_bit_n   = tx_bit + 3'd1;
            txd_n      = tx_shift[0];
            tx_shift_n = {1'b0, tx_shift[7:1]};
          end
        end
      endcase
    end
  end

  assign tx_idle = fifo_empty && (tx_state == TX_IDLE);

  // RX input select and synchroniser
  logic rx_in, rx_s1, rx_s2, rx_prev;

`ifdef IO_UART_LOOPBACK_EN
  logic loopback;

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST)                            loopback <= 1'b0;
    else if (bus.IOE && bus.IOA == 4'd3)   loopback <= bus.IOD[0];
  end

  assign rx_in = loopback ? TXD : RXD;
`else
  assign rx_in = RXD;
`endif

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX sampler: half-period wait after the falling edge lands later samples mid-bit
  rx_state_t   rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_done;

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_done    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_cnt_n   = {1'b0, divisor[15:1]};
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt != 16'd0) begin
          rx_cnt_n = rx_cnt - 16'd1;
        end else if (!rx_s2) begin
          rx_cnt_n   = divisor;
          rx_bit_n   = 3'd0;
          rx_state_n = RX_DATA;
        end else begin
          rx_state_n = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (rx_cnt != 16'd0) begin
          rx_cnt_n = rx_cnt - 16'd1;
        end else begin
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          rx_cnt_n   = divisor;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt != 16'd0) begin
          rx_cnt_n = rx_cnt - 16'd1;
        end else if (rx_s2) begin
          rx_done    = 1'b1;
          rx_state_n = RX_IDLE;
        end else begin
          rx_state_n = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s2) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // Register file; a set always beats a coincident clear
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      divisor  <= 16'(DIV_RESET);
      tx_ovf   <= 1'b0;
      rx_ovf   <= 1'b0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
    end else begin
      if (wr_div) divisor <= bus.IOD[15:0];

      if (wr_data && fifo_full) tx_ovf <= 1'b1;
      else if (clr_tx_ovf)      tx_ovf <= 1'b0;

      if (rx_done) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (clr_pop) begin
        rx_valid <= 1'b0;
      end

      if (rx_done && rx_valid && !clr_pop) rx_ovf <= 1'b1;
      else if (clr_rx_ovf)                 rx_ovf <= 1'b0;
    end
  end

  always_comb begin
    bus.IOQ = '0;
    case (bus.IOA)
      4'd0: bus.IOQ = {23'b0, rx_valid, rx_byte};
      4'd1: bus.IOQ = {27'b0, rx_ovf, tx_ovf, rx_valid, fifo_full, tx_idle};
      4'd2: bus.IOQ = {16'b0, divisor};
`ifdef IO_UART_LOOPBACK_EN
      4'd3: bus.IOQ = {31'b0, loopback};
`endif
      default: bus.IOQ = '0;
    endcase
  end
endmodule

// File: tb/tb_io_uart.sv
// tb/tb_io_uart.sv - randomized self-checking bench for io_uart against a frame-level behavioural model.
module tb_io_uart;
  localparam int DEPTH = 4;

  logic CLK   = 1'b0;
  logic N_RST = 1'b0;
  logic TXD;
  logic RXD   = 1'b1;

  io_uart_if bus();

  io_uart #(.TX_DEPTH_LOG2(2), .DIV_RESET(433)) dut (
    .CLK   (CLK),
    .N_RST (N_RST),
    .bus   (bus),
    .TXD   (TXD),
    .RXD   (RXD)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Behavioural model: FIFO as a queue, serialiser as a 10-bit frame indexed by elapsed time
  logic [7:0]  q[$];
  bit          m_busy     = 1'b0;
  int          m_t        = 0;
  int          m_per      = 1;
  logic [9:0]  m_frame    = '1;
  logic        m_txd      = 1'b1;
  logic [15:0] m_div      = 16'd433;
  bit          m_tx_ovf   = 1'b0;
  bit          m_rx_ovf   = 1'b0;
  bit          m_rx_valid = 1'b0;
  logic [7:0]  m_rx_byte  = '0;
  bit          m_lb       = 1'b0;

  bit          rx_inflight  = 1'b0;
  int          rx_pend_id   = 0;
  int          rx_done_id   = 0;
  logic [7:0]  rx_pend_byte = '0;
  bit          rx_pend_stop = 1'b0;

  always @(posedge CLK or negedge N_RST) begin : model
    int         pre;
    logic [7:0] head;
    if (!N_RST) begin
      q.delete();
      m_busy = 0; m_t = 0; m_txd = 1'b1; m_div = 16'd433;
      m_tx_ovf = 0; m_rx_ovf = 0; m_rx_valid = 0; m_rx_byte = '0; m_lb = 0;
      rx_done_id = rx_pend_id;
    end else begin
      pre = q.size();
      if (m_busy) begin
        m_t++;
        if (m_t == 10 * m_per) m_busy = 0;
      end
      if (!m_busy && pre > 0) begin
        head    = q.pop_front();
        m_frame = {1'b1, head, 1'b0};
        m_busy  = 1;
        m_t     = 0;
        m_per   = int'(m_div) + 1;
      end
      if (bus.IOE) begin
        case (bus.IOA)
          4'd0: if (pre < DEPTH) q.push_back(bus.IOD[7:0]); else m_tx_ovf = 1;
          4'd1: begin
            if (bus.IOD[0]) m_rx_valid = 0;
            if (bus.IOD[1]) m_tx_ovf   = 0;
            if (bus.IOD[2]) m_rx_ovf   = 0;
          end
          4'd2: m_div = bus.IOD[15:0];
`ifdef IO_UART_LOOPBACK_EN
          4'd3: m_lb = bus.IOD[0];
`endif
          default: ;
        endcase
      end
      if (rx_pend_id != rx_done_id) begin
        rx_done_id = rx_pend_id;
        if (rx_pend_stop) begin
          if (m_rx_valid) m_rx_ovf = 1;
          m_rx_valid = 1;
          m_rx_byte  = rx_pend_byte;
        end
      end
      m_txd = m_busy ? m_frame[m_t / m_per] : 1'b1;
    end
  end

  function automatic logic [31:0] exp_ioq(input logic [3:0] a);
    case (a)
      4'd0: return {23'b0, m_rx_valid, m_rx_byte};
      4'd1: return {27'b0, m_rx_ovf, m_tx_ovf, m_rx_valid, q.size() == DEPTH, q.size() == 0 && !m_busy};
      4'd2: return {16'b0, m_div};
      4'd3: return {31'b0, m_lb};
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.IOA = a; bus.IOD = d; bus.IOE = 1'b1;
    tick();
    bus.IOE = 1'b0; bus.IOA = 4'd1;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    bus.IOA = a;
    #1;
    chk(name, bus.IOQ, exp);
    bus.IOA = 4'd1;
  endtask

  task automatic push_burst(input int n);
    bus.IOA = 4'd0;
    for (int k = 0; k < n; k++) begin
      bus.IOD = $urandom; bus.IOE = 1'b1;
      tick();
    end
    bus.IOE = 1'b0; bus.IOA = 4'd1;
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while (!(q.size() == 0 && !m_busy) && n < 3000) begin
      bus.IOA = 4'($urandom_range(0, 15));
      tick();
      n++;
    end
    bus.IOA = 4'd1;
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL tx_idle_timeout: still busy after %0d cycles", n);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    int         per;
    logic [9:0] f;
    per = int'(m_div) + 1;
    f   = {stop, b, 1'b0};
    rx_inflight = 1'b1;
    for (int i = 0; i < 10; i++) begin
      RXD = f[i];
      repeat (per) tick();
    end
    RXD = 1'b1;
    repeat (2 * per) tick();
    rx_pend_byte = b; rx_pend_stop = stop; rx_pend_id++;
    tick(); tick();
    rx_inflight = 1'b0;
  endtask

  initial begin
    logic [9:0] lit55;
    bus.IOA = 4'd1; bus.IOD = '0; bus.IOE = 1'b0;
    lit55 = 10'b1010101010;

    fork
      forever begin
        logic [31:0] mask;
        @(negedge CLK);
        if (N_RST) begin
          chk("txd", {31'b0, TXD}, {31'b0, m_txd});
          mask = '1;
          if (rx_inflight) mask = (bus.IOA == 4'd0) ? 32'h0 : (bus.IOA == 4'd1) ? ~32'h14 : '1;
          if (mask != 32'h0)
            chk($sformatf("ioq[%0d]", bus.IOA), bus.IOQ & mask, exp_ioq(bus.IOA) & mask);
        end
      end
    join_none

    repeat (3) tick();
    chk("reset_txd", {31'b0, TXD}, 32'h1);
    rd_chk("reset_status", 4'd1, 32'h01);
    rd_chk("reset_div", 4'd2, 32'd433);
    rd_chk("reset_data", 4'd0, 32'h0);
    N_RST = 1'b1;
    tick();

    // 0x55 at DIVISOR=3: 40-cycle frame, 4 cycles per bit
    wr(4'd2, 32'd3);
    wr(4'd0, 32'h55);
    tick();
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      chk($sformatf("frame55[%0d]", i), {31'b0, TXD}, {31'b0, lit55[i / 4]});
    end
    tick();
    rd_chk("frame55_idle", 4'd1, 32'h01);

    // Six back-to-back pushes: one goes to the shifter, four fill the FIFO, the sixth drops
    push_burst(6);
    rd_chk("ovf_status", 4'd1, 32'h0A);
    wr(4'd1, 32'h2);
    rd_chk("ovf_cleared", 4'd1, 32'h02);
    wait_tx_idle();

    for (int it = 0; it < 16; it++) begin
      wait_tx_idle();
      wr(4'd2, 32'($urandom_range(0, 4)));
      push_burst($urandom_range(1, 6));
      repeat ($urandom_range(0, 40)) begin
        bus.IOA = 4'($urandom_range(0, 15));
        tick();
      end
      bus.IOA = 4'd1;
      push_burst($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) wr(4'd1, 32'h2);
    end
    wait_tx_idle();
    wr(4'd1, 32'h7);

    // RX directed
    wr(4'd2, 32'd7);
    send_rx(8'hA3, 1'b1);
    rd_chk("rx_a3", 4'd0, 32'h1A3);
    send_rx(8'h3C, 1'b1);
    rd_chk("rx_3c", 4'd0, 32'h13C);
    rd_chk("rx_ovf_status", 4'd1, 32'h15);
    wr(4'd1, 32'h5);
    rd_chk("rx_popped", 4'd0, 32'h03C);
    rd_chk("rx_pop_status", 4'd1, 32'h01);
    RXD = 1'b0; tick(); tick(); RXD = 1'b1;
    repeat (20) tick();
    rd_chk("false_start", 4'd0, 32'h03C);
    send_rx(8'h5A, 1'b0);
    rd_chk("frame_err", 4'd0, 32'h03C);

    for (int it = 0; it < 10; it++) begin
      wr(4'd2, 32'($urandom_range(3, 9)));
      send_rx(8'($urandom), $urandom_range(0, 3) != 0);
      bus.IOA = 4'd0; tick(); bus.IOA = 4'd1;
      if ($urandom_range(0, 2) == 0) wr(4'd1, 32'h5);
    end
    wr(4'd1, 32'h7);

`ifdef IO_UART_LOOPBACK_EN
    wr(4'd3, 32'h1);
    RXD = 1'b0;
    wr(4'd2, 32'd3);
    rx_inflight = 1'b1;
    wr(4'd0, 32'h96);
    repeat (50) tick();
    rx_pend_byte = 8'h96; rx_pend_stop = 1'b1; rx_pend_id++;
    tick(); tick();
    rx_inflight = 1'b0;
    rd_chk("loopback_data", 4'd0, 32'h196);
    RXD = 1'b1;
    wr(4'd3, 32'h0);
    wr(4'd1, 32'h7);
`endif

    // Reset in the middle of a frame of zeros
    wr(4'd2, 32'd3);
    wr(4'd0, 32'h00);
    repeat (10) tick();
    chk("pre_reset_txd", {31'b0, TXD}, 32'h0);
    N_RST = 1'b0;
    #1;
    chk("mid_reset_txd", {31'b0, TXD}, 32'h1);
    rd_chk("mid_reset_status", 4'd1, 32'h01);
    rd_chk("mid_reset_div", 4'd2, 32'd433);
    tick(); tick();
    N_RST = 1'b1;
    repeat (5) tick();
    chk("post_reset_txd", {31'b0, TXD}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
